axil_fifo_bridge: RTL and testbench

AXIL_FIFO_BRIDGE -- requirements
Module: axil_fifo_bridge

---
 rtl/axil_fifo_pkg.sv | 23 ++
 rtl/axil_cmd_arb.sv | 33 +++
 rtl/axil_fifo_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_axil_fifo_bridge.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_fifo_pkg.sv
// Shared types and constants for the AXI-Lite to FIFO command bridge.
package axil_fifo_pkg;

  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COLLECT,
    W_PUSH,
    W_RESP
  } w_state_e;

  typedef enum logic [2:0] {
    R_IDLE,
    R_PUSH,
    R_WAIT,
    R_POP,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axil_cmd_arb.sv
// Two-way grant for the command-order FIFO; priority flips only when both sides contend.
module axil_cmd_arb (
  input  logic clk,
  input  logic rst,
  input  logic req_w,
  input  logic req_r,
  output logic gnt_w_c,
  output logic gnt_r_c
);

  logic prio_w_q;
  logic prio_w_d;

  // Grant decode and priority update
  always_comb begin
    prio_w_d = prio_w_q;
    gnt_w_c  = req_w && (!req_r || prio_w_q);
    gnt_r_c  = req_r && (!req_w || !prio_w_q);
    if (req_w && req_r) begin
      prio_w_d = !prio_w_q;
    end
  end

  // Priority register, write side favoured out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_w_q <= 1'b1;
    end else begin
      prio_w_q <= prio_w_d;
    end
  end

endmodule

// File: rtl/axil_fifo_bridge.sv
// AXI-Lite slave that turns single-beat reads/writes into FIFO pushes and pops.
module axil_fifo_bridge
  import axil_fifo_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic              AXI_CLK,
  input  logic              ARESET,
  input  logic [SIZE-1:0]   AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [SIZE-1:0]   WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [RESP_W-1:0] BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [SIZE-1:0]   ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [SIZE-1:0]   RDATA,
  output logic [RESP_W-1:0] RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              WR_PUSH,
  output logic [SIZE-1:0]   WADDR_OUT,
  output logic [SIZE-1:0]   WDATA_OUT,
  input  logic              WADDR_FULL,
  input  logic              WDATA_FULL,
  output logic              RD_PUSH,
  output logic [SIZE-1:0]   RADDR_OUT,
  input  logic              RADDR_FULL,
  output logic              RW_PUSH,
  output logic              RW_OUT,
  input  logic              RW_FULL,
  output logic              RDATA_POP,
  input  logic [SIZE-1:0]   RDATA_IN,
  input  logic              RDATA_EMPTY
);

  w_state_e        w_state_q, w_state_d;
  r_state_e        r_state_q, r_state_d;
  logic            aw_got_q, aw_got_d;
  logic            w_got_q, w_got_d;
  logic [SIZE-1:0] awaddr_q, awaddr_d;
  logic [SIZE-1:0] wdata_q, wdata_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [SIZE-1:0] araddr_q, araddr_d;
  logic            arready_q, arready_d;
  logic [SIZE-1:0] rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;

  logic req_w_c, req_r_c;
  logic gnt_w_c, gnt_r_c;
  logic rdata_pop_c;

  // A side may only request the shared order FIFO when all of its own FIFOs have room
  assign req_w_c = (w_state_q == W_PUSH) && !WADDR_FULL && !WDATA_FULL && !RW_FULL;
  assign req_r_c = (r_state_q == R_PUSH) && !RADDR_FULL && !RW_FULL;

  axil_cmd_arb u_arb (
    .clk     (AXI_CLK),
    .rst     (ARESET),
    .req_w   (req_w_c),
    .req_r   (req_r_c),
    .gnt_w_c (gnt_w_c),
    .gnt_r_c (gnt_r_c)
  );

  // Strobes are decoded from state and live flags so they can never fire into a full/empty FIFO
  assign rdata_pop_c = (r_state_q == R_POP) && !RDATA_EMPTY;

  assign WR_PUSH   = gnt_w_c;
  assign RD_PUSH   = gnt_r_c;
  assign RW_PUSH   = gnt_w_c || gnt_r_c;
  assign RW_OUT    = gnt_w_c;
  assign RDATA_POP = rdata_pop_c;

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = RESP_OKAY;
  assign WADDR_OUT = awaddr_q;
  assign WDATA_OUT = wdata_q;
  assign ARREADY   = arready_q;
  assign RADDR_OUT = araddr_q;
  assign RDATA     = rdata_q;
  assign RRESP     = RESP_OKAY;
  assign RVALID    = rvalid_q;

  // Write path: collect AW and W in any order, push both together, then respond
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    bvalid_d  = bvalid_q;
    case (w_state_q)
      W_IDLE, W_COLLECT: begin
        if (AWVALID && awready_q) begin
          aw_got_d = 1'b1;
          awaddr_d = AWADDR;
        end
        if (WVALID && wready_q) begin
          w_got_d = 1'b1;
          wdata_d = WDATA;
        end
        if (aw_got_d && w_got_d) begin
          w_state_d = W_PUSH;
        end else if (aw_got_d || w_got_d) begin
          w_state_d = W_COLLECT;
        end
      end
      W_PUSH: begin
        if (gnt_w_c) begin
          w_state_d = W_RESP;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          bvalid_d  = 1'b1;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
    awready_d = ((w_state_d == W_IDLE) || (w_state_d == W_COLLECT)) && !aw_got_d;
    wready_d  = ((w_state_d == W_IDLE) || (w_state_d == W_COLLECT)) && !w_got_d;
  end

  // Read path: push address, wait for data, pop, then hold the response until accepted
  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID && arready_q) begin
          araddr_d  = ARADDR;
          r_state_d = R_PUSH;
        end
      end
      R_PUSH: begin
        if (gnt_r_c) begin
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (!RDATA_EMPTY) begin
          r_state_d = R_POP;
        end
      end
      R_POP: begin
        if (rdata_pop_c) begin
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        // FIFO data lands the cycle after the pop; latch it once, then hold for the master
        if (!rvalid_q) begin
          rdata_d  = RDATA_IN;
          rvalid_d = 1'b1;
        end else if (RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // State and output registers; reset drops any half-collected transaction
  always_ff @(posedge AXI_CLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      araddr_q  <= '0;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      araddr_q  <= araddr_d;
      arready_q <= arready_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_axil_fifo_bridge.sv
// Directed bench for axil_fifo_bridge with a small FIFO-side monitor.
module tb_axil_fifo_bridge;

  logic        AXI_CLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        WR_PUSH;
  logic [31:0] WADDR_OUT;
  logic [31:0] WDATA_OUT;
  logic        WADDR_FULL;
  logic        WDATA_FULL;
  logic        RD_PUSH;
  logic [31:0] RADDR_OUT;
  logic        RADDR_FULL;
  logic        RW_PUSH;
  logic        RW_OUT;
  logic        RW_FULL;
  logic        RDATA_POP;
  logic [31:0] RDATA_IN = 32'h0;
  logic        RDATA_EMPTY;

  int n_tests = 0;
  int n_fail  = 0;

  int          wr_push_cnt = 0;
  int          rd_push_cnt = 0;
  int          pop_cnt     = 0;
  int          viol_cnt    = 0;
  logic [31:0] last_waddr  = 32'h0;
  logic [31:0] last_wdata  = 32'h0;
  logic [31:0] rd_fifo_val = 32'h0;
  logic        rw_seq[$];

  axil_fifo_bridge #(.SIZE(32)) dut (
    .AXI_CLK     (AXI_CLK),
    .ARESET      (ARESET),
    .AWADDR      (AWADDR),
    .AWVALID     (AWVALID),
    .AWREADY     (AWREADY),
    .WDATA       (WDATA),
    .WVALID      (WVALID),
    .WREADY      (WREADY),
    .BRESP       (BRESP),
    .BVALID      (BVALID),
    .BREADY      (BREADY),
    .ARADDR      (ARADDR),
    .ARVALID     (ARVALID),
    .ARREADY     (ARREADY),
    .RDATA       (RDATA),
    .RRESP       (RRESP),
    .RVALID      (RVALID),
    .RREADY      (RREADY),
    .WR_PUSH     (WR_PUSH),
    .WADDR_OUT   (WADDR_OUT),
    .WDATA_OUT   (WDATA_OUT),
    .WADDR_FULL  (WADDR_FULL),
    .WDATA_FULL  (WDATA_FULL),
    .RD_PUSH     (RD_PUSH),
    .RADDR_OUT   (RADDR_OUT),
    .RADDR_FULL  (RADDR_FULL),
    .RW_PUSH     (RW_PUSH),
    .RW_OUT      (RW_OUT),
    .RW_FULL     (RW_FULL),
    .RDATA_POP   (RDATA_POP),
    .RDATA_IN    (RDATA_IN),
    .RDATA_EMPTY (RDATA_EMPTY)
  );

  always #5 AXI_CLK = ~AXI_CLK;

  // FIFO-side monitor: counts pushes/pops, records order, models one-cycle read latency
  always @(posedge AXI_CLK) begin
    if (!ARESET) begin
      if (WR_PUSH) begin
        wr_push_cnt <= wr_push_cnt + 1;
        last_waddr  <= WADDR_OUT;
        last_wdata  <= WDATA_OUT;
      end
      if (RD_PUSH) rd_push_cnt <= rd_push_cnt + 1;
      if (RW_PUSH) rw_seq.push_back(RW_OUT);
      if (RDATA_POP) begin
        pop_cnt  <= pop_cnt + 1;
        RDATA_IN <= rd_fifo_val;
      end
      if (WR_PUSH && (WADDR_FULL || WDATA_FULL || RW_FULL)) viol_cnt <= viol_cnt + 1;
      if (RD_PUSH && (RADDR_FULL || RW_FULL)) viol_cnt <= viol_cnt + 1;
      if (RDATA_POP && RDATA_EMPTY) viol_cnt <= viol_cnt + 1;
      if (WR_PUSH && RD_PUSH) viol_cnt <= viol_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge AXI_CLK);
    #1;
  endtask

  // Wait for BVALID (bounded), check response, then handshake it
  task automatic finish_write(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (BVALID) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_bvalid"}, 32'(seen), 32'd1);
    chk({tag, "_bresp"}, 32'(BRESP), 32'd0);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk({tag, "_bvalid_drop"}, 32'(BVALID), 32'd0);
  endtask

  // Offer one data word from the read FIFO and complete the R handshake
  task automatic finish_read(input string tag, input logic [31:0] data);
    logic seen = 1'b0;
    rd_fifo_val = data;
    RDATA_EMPTY = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (RDATA_POP) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_pop"}, 32'(seen), 32'd1);
    @(negedge AXI_CLK);
    RDATA_EMPTY = 1'b1;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (RVALID) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_rvalid"}, 32'(seen), 32'd1);
    chk({tag, "_rdata"}, RDATA, data);
    chk({tag, "_rresp"}, 32'(RRESP), 32'd0);
    tick();
    chk({tag, "_rdata_hold"}, RDATA, data);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    chk({tag, "_rvalid_drop"}, 32'(RVALID), 32'd0);
  endtask

  initial begin
    int base_wr;
    int base_rd;
    int base_pop;
    int base_seq;

    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    WADDR_FULL = 1'b0; WDATA_FULL = 1'b0; RADDR_FULL = 1'b0; RW_FULL = 1'b0;
    RDATA_EMPTY = 1'b1;

    // Reset state and ready timing after release
    tick();
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_rw_push", 32'(RW_PUSH), 32'd0);
    ARESET = 1'b0;
    #1;
    chk("rel_awready_pre_edge", 32'(AWREADY), 32'd0);
    tick();
    chk("rel_awready", 32'(AWREADY), 32'd1);
    chk("rel_wready", 32'(WREADY), 32'd1);
    chk("rel_arready", 32'(ARREADY), 32'd1);

    // AW and W in the same cycle
    base_wr = wr_push_cnt;
    AWADDR = 32'h100; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    #1;
    chk("same_awready_low", 32'(AWREADY), 32'd0);
    chk("same_wr_push", 32'(WR_PUSH), 32'd1);
    chk("same_rw_out", 32'(RW_OUT), 32'd1);
    chk("same_waddr", WADDR_OUT, 32'h100);
    chk("same_wdata", WDATA_OUT, 32'hDEADBEEF);
    tick();
    chk("same_push_once", 32'(WR_PUSH), 32'd0);
    finish_write("same");
    chk("same_push_count", 32'(wr_push_cnt - base_wr), 32'd1);
    chk("same_awready_back", 32'(AWREADY), 32'd1);

    // W three cycles ahead of AW
    base_wr = wr_push_cnt;
    WDATA = 32'hCAFEF00D; WVALID = 1'b1;
    tick();
    WVALID = 1'b0; WDATA = 32'h0BADBAD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("early_w_wready_low", 32'(WREADY), 32'd0);
      chk("early_w_awready_high", 32'(AWREADY), 32'd1);
      if (i < 2) tick();
    end
    AWADDR = 32'h200; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    #1;
    chk("early_w_push", 32'(WR_PUSH), 32'd1);
    chk("early_w_waddr", WADDR_OUT, 32'h200);
    chk("early_w_wdata", WDATA_OUT, 32'hCAFEF00D);
    tick();
    finish_write("early_w");
    chk("early_w_push_count", 32'(wr_push_cnt - base_wr), 32'd1);
    chk("early_w_mon_data", last_wdata, 32'hCAFEF00D);

    // Single read with data arriving five cycles later
    base_rd  = rd_push_cnt;
    base_pop = pop_cnt;
    ARADDR = 32'h40; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    #1;
    chk("rd_arready_low", 32'(ARREADY), 32'd0);
    chk("rd_push", 32'(RD_PUSH), 32'd1);
    chk("rd_rw_out", 32'(RW_OUT), 32'd0);
    chk("rd_raddr", RADDR_OUT, 32'h40);
    repeat (4) tick();
    chk("rd_no_early_pop", 32'(pop_cnt - base_pop), 32'd0);
    finish_read("rd", 32'h12345678);
    chk("rd_push_count", 32'(rd_push_cnt - base_rd), 32'd1);
    chk("rd_pop_count", 32'(pop_cnt - base_pop), 32'd1);
    chk("rd_arready_back", 32'(ARREADY), 32'd1);

    // Two contended rounds: write wins first, read wins second
    base_seq = rw_seq.size();
    AWADDR = 32'h300; AWVALID = 1'b1; WDATA = 32'h11112222; WVALID = 1'b1;
    ARADDR = 32'h80;  ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    #1;
    chk("arb1_wr_first", 32'(WR_PUSH), 32'd1);
    chk("arb1_rd_held", 32'(RD_PUSH), 32'd0);
    tick();
    chk("arb1_rd_second", 32'(RD_PUSH), 32'd1);
    chk("arb1_raddr", RADDR_OUT, 32'h80);
    tick();
    finish_write("arb1");
    finish_read("arb1", 32'hAAAA5555);
    AWADDR = 32'h304; AWVALID = 1'b1; WDATA = 32'h33334444; WVALID = 1'b1;
    ARADDR = 32'h84;  ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    #1;
    chk("arb2_rd_first", 32'(RD_PUSH), 32'd1);
    chk("arb2_wr_held", 32'(WR_PUSH), 32'd0);
    tick();
    chk("arb2_wr_second", 32'(WR_PUSH), 32'd1);
    chk("arb2_waddr", WADDR_OUT, 32'h304);
    tick();
    finish_write("arb2");
    finish_read("arb2", 32'h5555AAAA);
    chk("arb_seq_len", 32'(rw_seq.size() - base_seq), 32'd4);
    if (rw_seq.size() >= base_seq + 4) begin
      chk("arb_seq0", 32'(rw_seq[base_seq]),     32'd1);
      chk("arb_seq1", 32'(rw_seq[base_seq + 1]), 32'd0);
      chk("arb_seq2", 32'(rw_seq[base_seq + 2]), 32'd0);
      chk("arb_seq3", 32'(rw_seq[base_seq + 3]), 32'd1);
    end

    // Write held off by a full data FIFO for ten cycles
    base_wr = wr_push_cnt;
    WDATA_FULL = 1'b1;
    AWADDR = 32'h400; AWVALID = 1'b1; WDATA = 32'hA5A5A5A5; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; AWADDR = 32'hFFFF; WDATA = 32'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("full_no_push", 32'(WR_PUSH), 32'd0);
      chk("full_wdata_stable", WDATA_OUT, 32'hA5A5A5A5);
      tick();
    end
    chk("full_waddr_stable", WADDR_OUT, 32'h400);
    WDATA_FULL = 1'b0;
    #1;
    chk("full_release_push", 32'(WR_PUSH), 32'd1);
    tick();
    finish_write("full");
    chk("full_push_count", 32'(wr_push_cnt - base_wr), 32'd1);
    chk("full_mon_addr", last_waddr, 32'h400);

    // Reset while a read waits for data, then a clean read
    ARADDR = 32'h88; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    tick();
    ARESET = 1'b1;
    #1;
    chk("midrst_arready", 32'(ARREADY), 32'd0);
    chk("midrst_awready", 32'(AWREADY), 32'd0);
    chk("midrst_raddr", RADDR_OUT, 32'h0);
    chk("midrst_rd_push", 32'(RD_PUSH), 32'd0);
    chk("midrst_pop", 32'(RDATA_POP), 32'd0);
    tick();
    ARESET = 1'b0;
    tick();
    chk("midrst_arready_back", 32'(ARREADY), 32'd1);
    base_pop = pop_cnt;
    ARADDR = 32'h44; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    #1;
    chk("postrst_rd_push", 32'(RD_PUSH), 32'd1);
    chk("postrst_raddr", RADDR_OUT, 32'h44);
    tick();
    finish_read("postrst", 32'h0F0F0F0F);
    chk("postrst_pop_count", 32'(pop_cnt - base_pop), 32'd1);

    tick();
    chk("flag_violations", 32'(viol_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
